// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and encodings for the sequential magnitude comparator.
package seq_magnitude_comparator_pkg;

    // Controller states; encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Result encoding as {equal, greater, less}; exactly one bit set when valid.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_EQ   = 3'b100;
    localparam logic [2:0] RES_GT   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/seq_magnitude_comparator_slice.sv
// Combinational compare of one SLICE-bit slice. invert_msb flips the top bit of
// both operands, turning a two's-complement top slice into offset binary.
module seq_magnitude_comparator_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             invert_msb,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    logic [SLICE-1:0] a_adj;
    logic [SLICE-1:0] b_adj;

    // Apply the optional sign-bit inversion, then compare as unsigned.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        a_adj = a;
        b_adj = b;
        if (invert_msb) begin
            a_adj[SLICE-1] = ~a[SLICE-1];
            b_adj[SLICE-1] = ~b[SLICE-1];
        end
        eq = (a_adj == b_adj);
        gt = (a_adj >  b_adj);
        lt = (a_adj <  b_adj);
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the registered operands one slice per
// cycle from the MSB, signed or unsigned per operation, with optional early exit.
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SLICE      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             greater,
    output logic             less
);

    localparam int              NSLICE  = WIDTH / SLICE;
    localparam int              IDX_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NSLICE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic             sign_q;
    logic [IDX_W-1:0] idx;
    logic             pend_gt;
    logic             pend_lt;
    logic             pend_any;
    logic [SLICE-1:0] slice_x;
    logic [SLICE-1:0] slice_y;
    logic             invert_msb;
    logic             slice_eq;
    logic             slice_gt;
    logic             slice_lt;
    logic             accept;
    logic             decide;

    assign accept     = in_valid && in_ready;
    assign invert_msb = sign_q && (idx == TOP_IDX);
    assign pend_any   = pend_gt || pend_lt;
    // The walk ends on the first unequal slice (early exit) or on the last slice.
    assign decide     = (EARLY_EXIT && !slice_eq) || (idx == '0);

    // Select slice idx of both registered operands.
    always_comb begin
        slice_x = '0;
        slice_y = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                slice_x = x_q[i*SLICE +: SLICE];
                slice_y = y_q[i*SLICE +: SLICE];
            end
        end
    end

    seq_magnitude_comparator_slice #(
        .SLICE(SLICE)
    ) u_slice (
        .a          (slice_x),
        .b          (slice_y),
        .invert_msb (invert_msb),
        .eq         (slice_eq),
        .gt         (slice_gt),
        .lt         (slice_lt)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (decide) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture operands on accept, then step the slice index down while running.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: operand registers are reset as well; they are few and this keeps X out of the compare path after reset.
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            sign_q  <= 1'b0;
            idx     <= '0;
            pend_gt <= 1'b0;
            pend_lt <= 1'b0;
        end else if (accept) begin
            x_q     <= x;
            y_q     <= y;
            sign_q  <= sign;
            idx     <= TOP_IDX;
            pend_gt <= 1'b0;
            pend_lt <= 1'b0;
        end else if (state == ST_RUN && !decide) begin
            idx <= idx - IDX_W'(1);
            // Without early exit, remember the first unequal slice until the walk ends.
            if (!pend_any) begin
                pend_gt <= slice_gt;
                pend_lt <= slice_lt;
            end
        end
    end

    // Register the verdict on the deciding edge; it holds until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            equal   <= 1'b0;
            greater <= 1'b0;
            less    <= 1'b0;
        end else if (state == ST_RUN && decide) begin
            equal   <= !pend_any && slice_eq;
            greater <= pend_gt || (!pend_any && slice_gt);
            less    <= pend_lt || (!pend_any && slice_lt);
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: four instances cover early exit,
// full-length walks, WIDTH=8/SLICE=2 and the single-slice WIDTH==SLICE case.
module tb_seq_magnitude_comparator;
    import seq_magnitude_comparator_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  vld;
    logic [3:0]  ordy;
    logic [31:0] x;
    logic [31:0] y;
    logic        sign;
    wire  [3:0]  irdy;
    wire  [3:0]  ov;
    wire  [2:0]  r0, r1, r2, r3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(32), .SLICE(4), .EARLY_EXIT(1'b1)) u_w32 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_ready(irdy[0]),
        .x(x), .y(y), .sign(sign), .out_valid(ov[0]), .out_ready(ordy[0]),
        .equal(r0[2]), .greater(r0[1]), .less(r0[0]));

    seq_magnitude_comparator #(.WIDTH(32), .SLICE(4), .EARLY_EXIT(1'b0)) u_w32_full (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_ready(irdy[1]),
        .x(x), .y(y), .sign(sign), .out_valid(ov[1]), .out_ready(ordy[1]),
        .equal(r1[2]), .greater(r1[1]), .less(r1[0]));

    seq_magnitude_comparator #(.WIDTH(8), .SLICE(2), .EARLY_EXIT(1'b1)) u_w8 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_ready(irdy[2]),
        .x(x[7:0]), .y(y[7:0]), .sign(sign), .out_valid(ov[2]), .out_ready(ordy[2]),
        .equal(r2[2]), .greater(r2[1]), .less(r2[0]));

    seq_magnitude_comparator #(.WIDTH(4), .SLICE(4), .EARLY_EXIT(1'b1)) u_w4 (
        .clk(clk), .reset(reset), .in_valid(vld[3]), .in_ready(irdy[3]),
        .x(x[3:0]), .y(y[3:0]), .sign(sign), .out_valid(ov[3]), .out_ready(ordy[3]),
        .equal(r3[2]), .greater(r3[1]), .less(r3[0]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] get_res(input int d);
        case (d)
            0:       return r0;
            1:       return r1;
            2:       return r2;
            default: return r3;
        endcase
    endfunction

    // Reference result from plain signed/unsigned compares at width w (8 or 32).
    function automatic logic [2:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic s, input int w);
        logic signed [31:0] sa, sb;
        logic [31:0]        ua, ub;
        if (w == 8) begin
            ua = {24'd0, a[7:0]};
            ub = {24'd0, b[7:0]};
            sa = {{24{a[7]}}, a[7:0]};
            sb = {{24{b[7]}}, b[7:0]};
        end else begin
            ua = a; ub = b; sa = a; sb = b;
        end
        if (s) begin
            if (sa > sb) return RES_GT;
            if (sa < sb) return RES_LT;
        end else begin
            if (ua > ub) return RES_GT;
            if (ua < ub) return RES_LT;
        end
        return RES_EQ;
    endfunction

    // Early-exit latency: position (1-based, from MSB) of the first differing slice.
    function automatic int ref_k(input logic [31:0] a, input logic [31:0] b, input int w, input int sl);
        logic [31:0] d;
        for (int i = 1; i <= w / sl; i++) begin
            d = (a ^ b) >> (w - i * sl);
            if ((d & ((32'd1 << sl) - 32'd1)) != 32'd0) return i;
        end
        return w / sl;
    endfunction

    // One operation on DUT d with out_ready held high throughout; checks latency and result.
    task automatic run_op(input string tag, input int d, input logic [31:0] xa, input logic [31:0] ya,
                          input logic s, input logic [2:0] exp_res, input int exp_k);
        int k;
        @(negedge clk);
        x = xa; y = ya; sign = s;
        vld[d] = 1'b1; ordy[d] = 1'b1;
        check({tag, "_in_ready"}, 32'(irdy[d]), 32'd1);
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        x = ~xa; y = ~ya; sign = ~s;
        k = 0;
        while (ov[d] !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_k"}, 32'(k), 32'(exp_k));
        check({tag, "_res"}, 32'(get_res(d)), 32'(exp_res));
        check({tag, "_onehot"}, 32'($countones(get_res(d))), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_drain"}, 32'({ov[d], irdy[d]}), 32'b01);
        check({tag, "_held"}, 32'(get_res(d)), 32'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        logic [31:0] ra, rb;
        logic        rs;

        reset = 1'b1; vld = '0; ordy = '0; x = '0; y = '0; sign = 1'b0;
        #2;
        check("reset_in_ready", 32'(irdy), 32'hF);
        check("reset_out_valid", 32'(ov), 32'h0);
        check("reset_results", 32'({r0, r1, r2, r3}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Equal operands walk all 8 slices.
        run_op("eq_deadbeef", 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, RES_EQ, 8);
        // Top slice decides immediately; sign flips the verdict.
        run_op("msb_unsigned", 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, RES_GT, 1);
        run_op("msb_signed", 0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, RES_LT, 1);
        // Difference only in the bottom slice.
        run_op("low_slice", 0, 32'h0000_0005, 32'h0000_0007, 1'b1, RES_LT, 8);

        // Reset in the middle of a run: results drop, in_ready high while held.
        @(negedge clk);
        x = 32'h0000_0005; y = 32'h0000_0007; sign = 1'b1; vld[0] = 1'b1; ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(ov[0]), 32'd0);
        check("rst_mid_results", 32'(r0), 32'(RES_NONE));
        check("rst_mid_in_ready", 32'(irdy[0]), 32'd1);
        @(posedge clk);
        #1;
        check("rst_held_out_valid", 32'(ov[0]), 32'd0);
        check("rst_held_in_ready", 32'(irdy[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_reset", 0, 32'h0000_0005, 32'h0000_0007, 1'b1, RES_LT, 8);

        // Without early exit the walk is always full length.
        run_op("full_unsigned", 1, 32'hF000_0000, 32'h0000_0000, 1'b0, RES_GT, 8);
        run_op("full_signed", 1, 32'hF000_0000, 32'h0000_0000, 1'b1, RES_LT, 8);
        run_op("full_equal", 1, 32'h1234_5678, 32'h1234_5678, 1'b1, RES_EQ, 8);

        // Single-slice instance (WIDTH==SLICE): one RUN cycle.
        run_op("w4_signed", 3, 32'h9, 32'h3, 1'b1, RES_LT, 1);
        run_op("w4_unsigned", 3, 32'h9, 32'h3, 1'b0, RES_GT, 1);
        run_op("w4_equal", 3, 32'h5, 32'h5, 1'b0, RES_EQ, 1);

        // Narrow instance, sign-bit boundary.
        run_op("w8_signed", 2, 32'h80, 32'h7F, 1'b1, RES_LT, 1);
        run_op("w8_unsigned", 2, 32'h80, 32'h7F, 1'b0, RES_GT, 1);

        // Backpressure: result holds, in_valid pulses outside IDLE are ignored.
        @(negedge clk);
        x = 32'h0000_0001; y = 32'h0000_0002; sign = 1'b0; vld[0] = 1'b1; ordy[0] = 1'b0;
        @(posedge clk);
        #1;
        x = 32'hFFFF_FFFF; y = 32'h0000_0000;
        k = 0;
        while (ov[0] !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp_k", 32'(k), 32'd8);
        check("bp_res", 32'(r0), 32'(RES_LT));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'({ov[0], irdy[0]}), 32'b10);
            check("bp_hold_res", 32'(r0), 32'(RES_LT));
        end
        vld[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'({ov[0], irdy[0]}), 32'b01);
        ordy[0] = 1'b0;
        @(posedge clk);
        #1;
        check("bp_no_stray_accept", 32'({ov[0], irdy[0]}), 32'b01);

        // Back-to-back ops against the reference model, both widths and signs.
        for (int i = 0; i < 12; i++) begin
            ra = 32'($urandom_range(0, 255));
            if (i % 4 == 0)      rb = ra;
            else if (i % 4 == 1) rb = ra ^ (32'd1 << $urandom_range(0, 7));
            else                 rb = 32'($urandom_range(0, 255));
            rs = i[0];
            run_op("rnd_w8", 2, ra, rb, rs, ref_res(ra, rb, rs, 8), ref_k(ra, rb, 8, 2));
        end
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? (ra ^ (32'd1 << $urandom_range(0, 31))) : $urandom;
            rs = i[1];
            run_op("rnd_w32", 0, ra, rb, rs, ref_res(ra, rb, rs, 32), ref_k(ra, rb, 32, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
